// File: rtl/jk_drv_pkg.sv
// Shared types and constants for the JK flip-flop stimulus driver family.
// Excitation codes are packed as {j,k}.
package jk_drv_pkg;

   typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, CHECK} state_e;

   localparam logic [1:0] HOLD = 2'b00;
   localparam logic [1:0] RST  = 2'b01;
   localparam logic [1:0] SET  = 2'b10;
   localparam logic [1:0] TGL  = 2'b11;

   localparam int SETTLE_MAX = 15;

endpackage

// File: rtl/jk_excite_enc.sv
// Combinational JK excitation encoder: picks the {j,k} drive that moves
// a JK flip-flop from q_cur to q_tgt on its next clock.
module jk_excite_enc
   import jk_drv_pkg::*;
(
   input  logic       q_cur,
   input  logic       q_tgt,
   input  logic       use_toggle,
   output logic [1:0] jk
);

   always_comb begin
      jk = HOLD;
      if (q_cur != q_tgt) begin
         jk = use_toggle ? TGL : (q_tgt ? SET : RST);
      end
   end

endmodule

// File: rtl/jk_ff_driver.sv
// Drives a JK flip-flop towards a stream of target Q values, then checks the
// q/q_bar feedback after a settle window and keeps saturating pass/fail counts.
module jk_ff_driver
   import jk_drv_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1,
   parameter int USE_TOGGLE    = 0,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tgt_valid,
   input  logic             tgt_bit,
   output logic             tgt_ready,
   output logic             j,
   output logic             k,
   input  logic             q,
   input  logic             q_bar,
   output logic             err,
   output logic             err_sticky,
   output logic [CNT_W-1:0] done_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   generate
      if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > SETTLE_MAX) begin : g_bad_settle
         $error("jk_ff_driver: SETTLE_CYCLES out of range");
      end
   endgenerate

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

   state_e           state_q;
   logic             tgt_q;
   logic             q_exp_q;
   logic             ready_q;
   logic             j_q;
   logic             k_q;
   logic             err_q;
   logic             sticky_q;
   logic [3:0]       settle_q;
   logic [CNT_W-1:0] done_q;
   logic [CNT_W-1:0] errc_q;
   logic [1:0]       jk_d;
   logic             chk_fail;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Excitation is computed from the offered bit so j/k register on the accept edge.
   jk_excite_enc u_enc (
      .q_cur      (q_exp_q),
      .q_tgt      (tgt_bit),
      .use_toggle (USE_TOGGLE != 0),
      .jk         (jk_d)
   );

   assign chk_fail = (q != tgt_q) || (q_bar == q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         tgt_q    <= 1'b0;
         q_exp_q  <= 1'b0;
         ready_q  <= 1'b0;
         j_q      <= 1'b0;
         k_q      <= 1'b0;
         err_q    <= 1'b0;
         sticky_q <= 1'b0;
         settle_q <= 4'd0;
         done_q   <= '0;
         errc_q   <= '0;
      end else begin
         err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (tgt_valid && ready_q) begin
                  tgt_q      <= tgt_bit;
                  {j_q, k_q} <= jk_d;
                  ready_q    <= 1'b0;
                  state_q    <= DRIVE;
               end else begin
                  ready_q <= 1'b1;
               end
            end
            DRIVE: begin
               j_q      <= 1'b0;
               k_q      <= 1'b0;
               settle_q <= SETTLE_LOAD;
               state_q  <= SETTLE;
            end
            SETTLE: begin
               if (settle_q == 4'd0) state_q <= CHECK;
               else                  settle_q <= settle_q - 4'd1;
            end
            CHECK: begin
               // Adopt the observed Q so one failure does not cascade.
               q_exp_q <= q;
               done_q  <= sat_inc(done_q);
               ready_q <= 1'b1;
               state_q <= IDLE;
               if (chk_fail) begin
                  err_q    <= 1'b1;
                  sticky_q <= 1'b1;
                  errc_q   <= sat_inc(errc_q);
               end
            end
            default: begin
               j_q     <= 1'b0;
               k_q     <= 1'b0;
               ready_q <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign tgt_ready  = ready_q;
   assign j          = j_q;
   assign k          = k_q;
   assign err        = err_q;
   assign err_sticky = sticky_q;
   assign done_cnt   = done_q;
   assign err_cnt    = errc_q;

endmodule

// File: tb/tb_jk_ff_driver.sv
// Bench for jk_ff_driver: two driver instances (set/reset and toggle styles),
// each paired with a behavioural JK flip-flop, checked through a scoreboard.
module tb_jk_ff_driver;

   localparam int S0 = 1;
   localparam int S1 = 3;

   typedef struct {
      int jk;
      int err;
      int stk;
      int done;
      int errc;
      int q;
      int per;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [1:0]  tv, tbit, rdy, jo, ko, errp, stk, ffq, qb;
   logic [3:0]  dc0, ec0;
   logic [15:0] dc1, ec1;
   logic        force_q0, force_qb;
   int          sel;

   int total = 0;
   int bad   = 0;

   exp_t sb[$];
   exp_t cur;
   bit   busy = 0;
   int   cyc  = 0;

   int qexp_m[2], done_m[2], errc_m[2], stk_m[2];
   int per_of[2]  = '{S0 + 3, S1 + 3};
   int tgl_of[2]  = '{0, 1};
   int max_of[2]  = '{15, 65535};

   jk_ff_driver #(.SETTLE_CYCLES(S0), .USE_TOGGLE(0), .CNT_W(4)) u_d0 (
      .clk(clk), .reset(rst), .tgt_valid(tv[0]), .tgt_bit(tbit[0]), .tgt_ready(rdy[0]),
      .j(jo[0]), .k(ko[0]), .q(ffq[0]), .q_bar(qb[0]), .err(errp[0]),
      .err_sticky(stk[0]), .done_cnt(dc0), .err_cnt(ec0)
   );

   jk_ff_driver #(.SETTLE_CYCLES(S1), .USE_TOGGLE(1), .CNT_W(16)) u_d1 (
      .clk(clk), .reset(rst), .tgt_valid(tv[1]), .tgt_bit(tbit[1]), .tgt_ready(rdy[1]),
      .j(jo[1]), .k(ko[1]), .q(ffq[1]), .q_bar(qb[1]), .err(errp[1]),
      .err_sticky(stk[1]), .done_cnt(dc1), .err_cnt(ec1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural JK flip-flops; force_q0 clamps the selected one to 0.
   always @(posedge clk or posedge rst) begin
      if (rst) ffq <= 2'b00;
      else begin
         for (int i = 0; i < 2; i++) begin
            if (force_q0 && sel == i) ffq[i] <= 1'b0;
            else begin
               case ({jo[i], ko[i]})
                  2'b10:   ffq[i] <= 1'b1;
                  2'b01:   ffq[i] <= 1'b0;
                  2'b11:   ffq[i] <= ~ffq[i];
                  default: ffq[i] <= ffq[i];
               endcase
            end
         end
      end
   end

   assign qb[0] = (force_qb && sel == 0) ? ffq[0] : ~ffq[0];
   assign qb[1] = (force_qb && sel == 1) ? ffq[1] : ~ffq[1];

   wire mon_rdy = rdy[sel];
   wire mon_vld = tv[sel];
   wire mon_j   = jo[sel];
   wire mon_k   = ko[sel];
   wire mon_err = errp[sel];
   wire mon_stk = stk[sel];
   wire mon_q   = ffq[sel];
   wire [15:0] mon_done = (sel == 1) ? dc1 : {12'd0, dc0};
   wire [15:0] mon_errc = (sel == 1) ? ec1 : {12'd0, ec0};

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t inst=%0d)", name, act, req, $time, sel);
      end
   endtask

   function automatic int exp_jk(input int from, input int to, input int tgl);
      if (from == to) return 0;
      if (tgl != 0)   return 3;
      return (to != 0) ? 2 : 1;
   endfunction

   function automatic int sat(input int v, input int m);
      return (v >= m) ? m : v + 1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         qexp_m[i] = 0; done_m[i] = 0; errc_m[i] = 0; stk_m[i] = 0;
      end
   endtask

   // Caller is always just after a rising edge.
   task automatic send(input int tgt, input bit f0, input bit fb);
      exp_t e;
      int   n;
      int   qa;
      n = 0;
      while (!mon_rdy && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (!mon_rdy) begin
         chk("ready_timeout", 0, 1);
         return;
      end
      qa       = f0 ? 0 : tgt;
      e.jk     = exp_jk(qexp_m[sel], tgt, tgl_of[sel]);
      e.err    = ((qa != tgt) || fb) ? 1 : 0;
      e.q      = qa;
      e.per    = per_of[sel];
      qexp_m[sel] = qa;
      done_m[sel] = sat(done_m[sel], max_of[sel]);
      if (e.err != 0) begin
         errc_m[sel] = sat(errc_m[sel], max_of[sel]);
         stk_m[sel]  = 1;
      end
      e.done = done_m[sel];
      e.errc = errc_m[sel];
      e.stk  = stk_m[sel];
      sb.push_back(e);
      force_q0  = f0;
      force_qb  = fb;
      tv[sel]   = 1'b1;
      tbit[sel] = tgt[0];
      @(posedge clk); #1;
      tv[sel]   = 1'b0;
      tbit[sel] = 1'($urandom);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || busy) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (sb.size() != 0 || busy) chk("drain_timeout", 0, 1);
   endtask

   // Monitor: pops an expectation on each accepted handshake, follows it to completion.
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         busy = 0;
      end else begin
         if (busy) begin
            cyc++;
            if (cyc == 1) chk("drive_jk", int'({mon_j, mon_k}), cur.jk);
            else if (!mon_rdy) chk("quiet_jk", int'({mon_j, mon_k}), 0);
            if (mon_rdy) begin
               chk("period", cyc, cur.per);
               chk("err", int'(mon_err), cur.err);
               chk("err_sticky", int'(mon_stk), cur.stk);
               chk("done_cnt", int'(mon_done), cur.done);
               chk("err_cnt", int'(mon_errc), cur.errc);
               chk("q", int'(mon_q), cur.q);
               busy = 0;
            end else begin
               chk("err_busy", int'(mon_err), 0);
               if (cyc > 40) begin
                  chk("done_timeout", 0, 1);
                  busy = 0;
               end
            end
         end else begin
            chk("err_idle", int'(mon_err), 0);
         end
         if (!busy && mon_rdy && mon_vld) begin
            if (sb.size() == 0) chk("spurious_accept", 1, 0);
            else begin
               cur  = sb.pop_front();
               busy = 1;
               cyc  = 0;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; tv = 2'b00; tbit = 2'b00; force_q0 = 1'b0; force_qb = 1'b0; sel = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", int'(rdy[0]), 0);
      chk("rst_jk", int'({jo[0], ko[0], jo[1], ko[1]}), 0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("rel_ready0", int'(rdy[0]), 1);
      chk("rel_ready1", int'(rdy[1]), 1);
      chk("rel_jk", int'({jo[0], ko[0]}), 0);
      chk("rel_err", int'(errp[0]), 0);
      chk("rel_sticky", int'(stk[0]), 0);
      chk("rel_done", int'(dc0), 0);
      chk("rel_errc", int'(ec0), 0);

      // Set/reset excitation, including holds.
      send(1, 0, 0); send(1, 0, 0); send(0, 0, 0); send(0, 0, 0);
      drain();

      // Toggle-style instance with a longer settle window.
      sel = 1;
      @(posedge clk); #1;
      send(1, 0, 0); send(0, 0, 0); send(1, 0, 0);
      for (int i = 0; i < 8; i++) send(int'($urandom_range(0, 1)), 0, 0);
      drain();

      // Fault injection on the set/reset instance.
      sel = 0;
      @(posedge clk); #1;
      send(1, 1, 0);
      send(0, 0, 0);
      send(1, 0, 1);
      for (int i = 0; i < 10; i++)
         send(int'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
      send(0, 0, 0);

      // Asynchronous reset in the middle of the settle window.
      send(1, 0, 0);
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      chk("mid_rst_jk", int'({jo[0], ko[0]}), 0);
      chk("mid_rst_ready", int'(rdy[0]), 0);
      chk("mid_rst_sticky", int'(stk[0]), 0);
      chk("mid_rst_done", int'(dc0), 0);
      chk("mid_rst_errc", int'(ec0), 0);
      chk("mid_rst_q", int'(ffq[0]), 0);
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      force_q0 = 1'b0;
      force_qb = 1'b0;
      model_reset();
      @(posedge clk); #1;
      send(1, 0, 0);

      // Saturation of the 4-bit done counter.
      for (int i = 0; i < 21; i++) send(int'($urandom_range(0, 1)), 0, 0);
      drain();
      chk("done_saturated", int'(dc0), 15);
      chk("errc_after_rst", int'(ec0), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
